imm_encoder: RTL

Pipelined immediate encoder for the OTTER core's toolchain/test path: it takes a base instruction word, an instruction-format selector and a 32-bit immediate value, then scatters the immediate into the format's bit fields. Its output decodes back to the same immediate through the core's immediate generator. It uses a two-stage valid/ready pipeline with a per-word error flag and delivery/error counters. It feeds the instruction-memory loader and the self-check benches.

---
 rtl/imm_encoder.sv | 129 ++++++++++++
 1 files changed

// File: rtl/imm_encoder.sv
// imm_encoder: two-stage valid/ready immediate encoder for the OTTER core.
// Scatters a 32-bit immediate into the I/S/B/U/J fields of a base instruction.
// Stage 1 registers the request and its error bit. Stage 2 registers the packed word.
// Also counts delivered words (wrapping) and errored words (saturating).
// Optional build macro: IMM_ENC_RANGE_CHK_EN. When it is defined, OUT_ERR also
// flags immediates that do not fit the format.
module imm_encoder (
  input  logic        CLK,
  input  logic        RST_N,
  input  logic        IN_VLD,
  output logic        IN_RDY,
  input  logic [2:0]  IN_TYP,
  input  logic [31:0] IN_BASE,
  input  logic [31:0] IN_IMM,
  output logic        OUT_VLD,
  input  logic        OUT_RDY,
  output logic [31:0] OUT_INS,
  output logic        OUT_ERR,
  output logic [15:0] ENC_CNT,
  output logic [7:0]  ERR_CNT
);

  localparam logic [2:0] TYP_I = 3'd0;
  localparam logic [2:0] TYP_S = 3'd1;
  localparam logic [2:0] TYP_B = 3'd2;
  localparam logic [2:0] TYP_U = 3'd3;
  localparam logic [2:0] TYP_J = 3'd4;

  typedef struct packed {
    logic [2:0]  typ;
    logic [31:0] base;
    logic [31:0] imm;
    logic        err;
  } s1_t;

  // vld_pipe[1] = stage 1 occupied, vld_pipe[2] = stage 2 occupied (output)
  logic [2:1] vld_pipe;
  s1_t        s1;
  logic       s1_load, s2_load, deliver;
  logic       in_err;
  logic [31:0] packed_ins;

  // Ready chain: a stage may load if it is empty or its successor is loading.
  assign s2_load = !vld_pipe[2] || OUT_RDY;
  assign s1_load = !vld_pipe[1] || s2_load;
  assign IN_RDY  = s1_load && RST_N;
  assign OUT_VLD = vld_pipe[2];
  assign deliver = vld_pipe[2] && OUT_RDY;

  // Error classification of the incoming word (illegal type, optional range rules)
  always_comb begin
    in_err = 1'b0;
    case (IN_TYP)
`ifdef IMM_ENC_RANGE_CHK_EN
      TYP_I, TYP_S: in_err = (IN_IMM[31:12] != {20{IN_IMM[11]}});
      TYP_B:        in_err = (IN_IMM[31:13] != {19{IN_IMM[12]}}) || IN_IMM[0];
      TYP_U:        in_err = (IN_IMM[11:0] != 12'd0);
      TYP_J:        in_err = (IN_IMM[31:21] != {11{IN_IMM[20]}}) || IN_IMM[0];
`else
      TYP_I, TYP_S, TYP_B, TYP_U, TYP_J: in_err = 1'b0;
`endif
      default:      in_err = 1'b1;
    endcase
  end

  // Scatter the stage-1 immediate into the format's fields; out-of-range bits are truncated
  always_comb begin
    packed_ins = s1.base;
    case (s1.typ)
      TYP_I: packed_ins[31:20] = s1.imm[11:0];
      TYP_S: begin
        packed_ins[31:25] = s1.imm[11:5];
        packed_ins[11:7]  = s1.imm[4:0];
      end
      TYP_B: begin
        packed_ins[31]    = s1.imm[12];
        packed_ins[7]     = s1.imm[11];
        packed_ins[30:25] = s1.imm[10:5];
        packed_ins[11:8]  = s1.imm[4:1];
      end
      TYP_U: packed_ins[31:12] = s1.imm[31:12];
      TYP_J: begin
        packed_ins[31]    = s1.imm[20];
        packed_ins[19:12] = s1.imm[19:12];
        packed_ins[20]    = s1.imm[11];
        packed_ins[30:21] = s1.imm[10:1];
      end
      default: packed_ins = s1.base;
    endcase
  end

  // Stage 1: capture the accepted request
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      vld_pipe[1] <= 1'b0;
      s1          <= '0;
    end else if (s1_load) begin
      vld_pipe[1] <= IN_VLD;
      if (IN_VLD) s1 <= '{typ: IN_TYP, base: IN_BASE, imm: IN_IMM, err: in_err};
    end
  end

  // Stage 2: capture the packed word; held stable while stalled
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      vld_pipe[2] <= 1'b0;
      OUT_INS     <= '0;
      OUT_ERR     <= 1'b0;
    end else if (s2_load) begin
      vld_pipe[2] <= vld_pipe[1];
      if (vld_pipe[1]) begin
        OUT_INS <= packed_ins;
        OUT_ERR <= s1.err;
      end
    end
  end

  // Delivery counters: total wraps, error count saturates
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      ENC_CNT <= '0;
      ERR_CNT <= '0;
    end else if (deliver) begin
      ENC_CNT <= ENC_CNT + 16'd1;
      if (OUT_ERR && ERR_CNT != 8'hFF) ERR_CNT <= ERR_CNT + 8'd1;
    end
  end

endmodule
